btn_debounce: RTL and testbench

Synchronizes and debounces a raw board push-button and turns it into clean, single-cycle events for the LED and control logic downstream. It sits directly between the `btn` pad and any consumer of button state, such as the LED blinker. It provides a stable level plus press, release and long-press pulses, all in the `sysclk` domain.

---
 rtl/btn_debounce.sv | 170 +++++++++++++++++
 tb/tb_btn_debounce.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronizes the raw pad input and debounces it.
// Produces a stable level and single-cycle press, release and long-press pulses.
module btn_debounce #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned LONG_PRESS_CYCLES = 12000000,
  parameter bit          ACTIVE_LOW        = 1'b0
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HCNT_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_PRESS_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_FIRE = HCNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

  typedef enum logic [1:0] {
    ST_RELEASED      = 2'd0,
    ST_CHECK_PRESS   = 2'd1,
    ST_PRESSED       = 2'd2,
    ST_CHECK_RELEASE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DCNT_W-1:0]      r_dcnt;
  logic [DCNT_W-1:0]      w_dcnt_nxt;
  logic [HCNT_W-1:0]      r_hcnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_long;
  logic                   w_btn_act;
  logic                   w_s;
  logic                   w_accept_press;
  logic                   w_accept_release;
  logic                   w_level_nxt;
  logic                   w_press_nxt;
  logic                   w_release_nxt;
  logic                   w_long_nxt;

  // Polarity normalisation happens ahead of the first flop so the chain resets to "released".
  assign w_btn_act = btn ^ ACTIVE_LOW;
  assign w_s       = r_sync[SYNC_STAGES-1];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn_act};
    end
  end

  // State register, debounce counter and registered outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RELEASED;
      r_dcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
    end
  end

  // Next state: any opposite sample inside a CHECK state abandons the window.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      ST_RELEASED: begin
        if (w_s) begin
          w_state_nxt = ST_CHECK_PRESS;
          w_dcnt_nxt  = DCNT_ONE;
        end else begin
          w_dcnt_nxt  = '0;
        end
      end
      ST_CHECK_PRESS: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASED;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_dcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt  = r_dcnt + DCNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!w_s) begin
          w_state_nxt = ST_CHECK_RELEASE;
          w_dcnt_nxt  = DCNT_ONE;
        end else begin
          w_dcnt_nxt  = '0;
        end
      end
      ST_CHECK_RELEASE: begin
        if (w_s) begin
          w_state_nxt = ST_PRESSED;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt = ST_RELEASED;
          w_dcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt  = r_dcnt + DCNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_dcnt_nxt  = '0;
      end
    endcase
  end

  // Output decode; values are registered above.
  always_comb begin
    w_accept_press   = 1'b0;
    w_accept_release = 1'b0;
    w_level_nxt      = r_level;
    w_press_nxt      = 1'b0;
    w_release_nxt    = 1'b0;
    w_long_nxt       = r_level && (r_hcnt == HCNT_FIRE);
    if ((r_state == ST_CHECK_PRESS) && w_s && (r_dcnt == DCNT_LAST)) begin
      w_accept_press = 1'b1;
      w_level_nxt    = 1'b1;
      w_press_nxt    = 1'b1;
    end
    if ((r_state == ST_CHECK_RELEASE) && !w_s && (r_dcnt == DCNT_LAST)) begin
      w_accept_release = 1'b1;
      w_level_nxt      = 1'b0;
      w_release_nxt    = 1'b1;
    end
  end

  // Hold counter: runs while the level is high, saturates so the long pulse cannot repeat.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
    end else if (w_accept_press) begin
      r_hcnt <= '0;
    end else if (r_level && (r_hcnt != HCNT_MAX)) begin
      r_hcnt <= r_hcnt + HCNT_ONE;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_long    = r_long;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random button activity against a
// run-length reference model; an ACTIVE_LOW copy gets inverted stimulus and must match.
module tb_btn_debounce;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DC   = 8;
  localparam int unsigned LONG = 40;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic btn    = 1'b1;
  logic btn_inv;
  logic lvl0, prs0, rel0, lng0;
  logic lvl1, prs1, rel1, lng1;

  assign btn_inv = ~btn;

  always #5 sysclk = ~sysclk;

  btn_debounce #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .sysclk(sysclk), .rst_n(rst_n), .btn(btn),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0), .btn_long(lng0)
  );

  btn_debounce #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1'b1)
  ) u_dut_lo (
    .sysclk(sysclk), .rst_n(rst_n), .btn(btn_inv),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1), .btn_long(lng1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: delayed samples, run of opposite samples, accepted level, press edge.
  logic dq[$];
  int   run;
  logic m_level, m_press, m_rel, m_long;
  int   press_edge;
  int   cyc = 0;

  int n_press = 0, n_rel = 0, n_long = 0;
  int last_press_cyc = -1000, last_rel_cyc = -1000, last_long_cyc = -1000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    for (int i = 0; i < int'(SYNC); i++) dq.push_back(1'b0);
    run     = 0;
    m_level = 1'b0;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
  endtask

  task automatic model_edge();
    logic fin;
    logic lvl_before;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      fin = dq.pop_front();
      dq.push_back(btn);
      lvl_before = m_level;
      if (fin != m_level) run++;
      else run = 0;
      if (run == int'(DC)) begin
        run     = 0;
        m_level = ~m_level;
        if (m_level) begin
          m_press    = 1'b1;
          press_edge = cyc;
        end else begin
          m_rel = 1'b1;
        end
      end
      if (lvl_before && (cyc - press_edge == int'(LONG))) m_long = 1'b1;
    end
  endtask

  // One clock edge: advance the model, then compare both DUTs just after the edge.
  task automatic step();
    @(posedge sysclk);
    cyc++;
    model_edge();
    #1;
    check("level_hi",   32'(lvl0), 32'(m_level));
    check("press_hi",   32'(prs0), 32'(m_press));
    check("release_hi", 32'(rel0), 32'(m_rel));
    check("long_hi",    32'(lng0), 32'(m_long));
    check("level_lo",   32'(lvl1), 32'(m_level));
    check("press_lo",   32'(prs1), 32'(m_press));
    check("release_lo", 32'(rel1), 32'(m_rel));
    check("long_lo",    32'(lng1), 32'(m_long));
    if (prs0) begin n_press++; last_press_cyc = cyc; end
    if (rel0) begin n_rel++;   last_rel_cyc   = cyc; end
    if (lng0) begin n_long++;  last_long_cyc  = cyc; end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_level",   32'(lvl0 | lvl1), 32'd0);
    check("rst_async_press",   32'(prs0 | prs1), 32'd0);
    check("rst_async_release", 32'(rel0 | rel1), 32'd0);
    check("rst_async_long",    32'(lng0 | lng1), 32'd0);
    model_reset();
    hold(3);
    @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  int c0, p0, r0, l0;

  initial begin
    model_reset();
    press_edge = -1000;

    // Button held through reset: a fresh press after full latency.
    hold(3);
    check("rst_level", 32'(lvl0), 32'd0);
    @(negedge sysclk);
    rst_n = 1'b1;
    c0 = cyc + 1; p0 = n_press;
    hold(20);
    check("rst_press_lat", 32'(last_press_cyc - c0), 32'd9);
    check("rst_press_cnt", 32'(n_press - p0), 32'd1);
    btn = 1'b0; hold(20);

    // Clean press and release.
    p0 = n_press; btn = 1'b1; c0 = cyc + 1; hold(20);
    check("clean_press_lat", 32'(last_press_cyc - c0), 32'd9);
    check("clean_press_cnt", 32'(n_press - p0), 32'd1);
    r0 = n_rel; btn = 1'b0; c0 = cyc + 1; hold(20);
    check("clean_rel_lat", 32'(last_rel_cyc - c0), 32'd9);
    check("clean_rel_cnt", 32'(n_rel - r0), 32'd1);

    // Bounce 1,0,1,0 with 3-cycle dwell, then hold.
    p0 = n_press;
    btn = 1'b1; hold(3); btn = 1'b0; hold(3);
    btn = 1'b1; hold(3); btn = 1'b0; hold(3);
    check("bounce_no_press", 32'(n_press - p0), 32'd0);
    btn = 1'b1; c0 = cyc + 1; hold(20);
    check("bounce_press_lat", 32'(last_press_cyc - c0), 32'd9);
    check("bounce_press_cnt", 32'(n_press - p0), 32'd1);
    btn = 1'b0; hold(20);

    // Long press.
    p0 = n_press; l0 = n_long; r0 = n_rel;
    btn = 1'b1; c0 = cyc + 1; hold(100);
    check("long_press_lat", 32'(last_press_cyc - c0), 32'd9);
    check("long_delay", 32'(last_long_cyc - last_press_cyc), 32'(LONG));
    check("long_cnt", 32'(n_long - l0), 32'd1);
    btn = 1'b0; hold(20);
    check("long_rel_cnt", 32'(n_rel - r0), 32'd1);

    // Short press: no long pulse.
    p0 = n_press; l0 = n_long; r0 = n_rel;
    btn = 1'b1; hold(20); btn = 1'b0; hold(20);
    check("short_press_cnt", 32'(n_press - p0), 32'd1);
    check("short_rel_cnt", 32'(n_rel - r0), 32'd1);
    check("short_long_cnt", 32'(n_long - l0), 32'd0);

    // Glitch while pressed: no release, hold counting continues.
    l0 = n_long; r0 = n_rel;
    btn = 1'b1; hold(15); btn = 1'b0; hold(3); btn = 1'b1; hold(60);
    check("glitch_rel_cnt", 32'(n_rel - r0), 32'd0);
    check("glitch_long_delay", 32'(last_long_cyc - last_press_cyc), 32'(LONG));
    btn = 1'b0; hold(20);

    // Release accepted on the very cycle the hold counter fires: both pulse.
    l0 = n_long;
    btn = 1'b1; hold(40); btn = 1'b0; hold(20);
    check("coinc_long_cnt", 32'(n_long - l0), 32'd1);
    check("coinc_same_cycle", 32'(last_long_cyc - last_rel_cyc), 32'd0);

    // Release accepted one cycle earlier: no long pulse.
    l0 = n_long;
    btn = 1'b1; hold(39); btn = 1'b0; hold(20);
    check("early_rel_no_long", 32'(n_long - l0), 32'd0);

    // Reset mid-press: no release pulse, held button re-detected as a press.
    btn = 1'b1; hold(30);
    r0 = n_rel;
    do_reset();
    check("midrst_no_release", 32'(n_rel - r0), 32'd0);
    p0 = n_press; c0 = cyc + 1; hold(20);
    check("midrst_press_lat", 32'(last_press_cyc - c0), 32'd9);
    check("midrst_press_cnt", 32'(n_press - p0), 32'd1);
    btn = 1'b0; hold(20);

    // Random activity with occasional resets.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        do_reset();
      end else begin
        btn = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) hold(int'($urandom_range(30, 60)));
        else hold(int'($urandom_range(1, 12)));
      end
    end
    btn = 1'b0; hold(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
